// File: rtl/tmds_ddr_sequencer_pkg.sv
// Shared HDMI transmitter constants and types.
// Used by the TMDS DDR output sequencer and its pair slicer.
package hdmi_pkg;

  localparam int TMDS_W = 10;
  localparam int PAIRS  = 5;
  localparam int LANES  = 4;

  localparam logic [TMDS_W-1:0] IDLE_SYM = 10'h354;
  localparam logic [TMDS_W-1:0] CLK_PAT  = 10'h01F;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/tmds_ddr_sequencer_if.sv
// Valid/ready symbol-triple channel from the TMDS encoders.
// master drives the triple, slave returns ready.
interface tmds_sym_if;
  import hdmi_pkg::*;

  logic [3*TMDS_W-1:0] sym_data;
  logic                sym_valid;
  logic                sym_ready;

  modport master (
    output sym_data,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_data,
    input  sym_valid,
    output sym_ready
  );

endinterface

// File: rtl/tmds_ddr_sequencer_slicer.sv
// Selects the (D0, D1) bit pair of a TMDS word for a phase.
// Phase k yields bits 2k and 2k+1 (LSB first).
module tmds_pair_slicer
  import hdmi_pkg::*;
(
  input  logic [TMDS_W-1:0] word,
  input  logic [2:0]        phase,
  output logic              d0,
  output logic              d1
);

  always_comb begin
    d0 = 1'b0;
    d1 = 1'b0;
    unique case (phase)
      3'd0: begin d0 = word[0]; d1 = word[1]; end
      3'd1: begin d0 = word[2]; d1 = word[3]; end
      3'd2: begin d0 = word[4]; d1 = word[5]; end
      3'd3: begin d0 = word[6]; d1 = word[7]; end
      3'd4: begin d0 = word[8]; d1 = word[9]; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tmds_ddr_sequencer.sv
// HDMI ODDR sequencer: one-deep symbol buffer, 5-phase pair
// serialisation, start/stop control and underrun substitution.
module tmds_ddr_sequencer
  import hdmi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  tmds_sym_if.slave        sym,
  output logic [7:0]       ddr_din,
  output logic             sym_strobe,
  output logic             busy,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  localparam int SW = 3 * TMDS_W;

  state_t          state_q;
  state_t          state_d;
  logic [2:0]      p_q;
  logic [2:0]      p_d;
  logic [SW-1:0]   hold_q;
  logic            hold_full;
  logic [SW-1:0]   word_q;
  logic [SW-1:0]   word_d;
  logic [SW-1:0]   load_word;
  logic            consume;
  logic            accept;
  logic            starve;
  logic            emit;
  logic [LANES-1:0] d0;
  logic [LANES-1:0] d1;

  // A stopping link (en=0 at p=4) must not consume, so the
  // hold entry survives the stop and leads after restart.
  assign consume = en & ((state_q == RUN && p_q == 3'd4)
                      | (state_q == IDLE));
  assign sym.sym_ready = !hold_full | consume;
  assign accept = sym.sym_valid & sym.sym_ready;
  assign load_word = hold_full ? hold_q : {3{IDLE_SYM}};
  assign starve = consume & !hold_full & (state_q == RUN);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          p_d     = 3'd0;
          word_d  = load_word;
        end
      end
      RUN: begin
        if (p_q != 3'd4) begin
          p_d = p_q + 3'd1;
        end else if (en) begin
          p_d    = 3'd0;
          word_d = load_word;
        end else begin
          state_d = IDLE;
          p_d     = 3'd0;
        end
      end
      default: ;
    endcase
  end

  assign emit = (state_d == RUN);

  for (genvar i = 0; i < LANES - 1; i++) begin : g_lane
    tmds_pair_slicer u_slice (
      .word  (word_d[i*TMDS_W +: TMDS_W]),
      .phase (p_d),
      .d0    (d0[i]),
      .d1    (d1[i])
    );
  end

  tmds_pair_slicer u_clk_slice (
    .word  (CLK_PAT),
    .phase (p_d),
    .d0    (d0[LANES-1]),
    .d1    (d1[LANES-1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      p_q          <= 3'd0;
      word_q       <= '0;
      hold_q       <= '0;
      hold_full    <= 1'b0;
      ddr_din      <= 8'h00;
      sym_strobe   <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      word_q     <= word_d;
      ddr_din    <= emit ? {d1, d0} : 8'h00;
      sym_strobe <= emit & (p_d == 3'd0);
      busy       <= emit;
      underrun   <= starve;
      if (starve && !(&underrun_cnt))
        underrun_cnt <= underrun_cnt + 1'b1;
      if (accept) begin
        hold_q    <= sym.sym_data;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_ddr_sequencer.sv
// Directed bench for tmds_ddr_sequencer (CNT_W=4 so the
// counter saturates quickly).
module tb_tmds_ddr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] ddr_din;
  logic       sym_strobe;
  logic       busy;
  logic       underrun;
  logic [3:0] underrun_cnt;

  int checks = 0;
  int errors = 0;

  tmds_sym_if s ();

  tmds_ddr_sequencer #(.CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sym          (s.slave),
    .ddr_din      (ddr_din),
    .sym_strobe   (sym_strobe),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: lane l D0 = bit 2ph, D1 = bit 2ph+1.
  function automatic logic [7:0] exp_byte(input logic [29:0] t,
                                          input int ph);
    logic [9:0] w;
    logic [9:0] ck;
    logic [7:0] b;
    ck = 10'b0000011111;
    b = 8'h00;
    for (int l = 0; l < 3; l++) begin
      w = t[10*l +: 10];
      b[l]   = w[2*ph];
      b[l+4] = w[2*ph+1];
    end
    b[3] = ck[2*ph];
    b[7] = ck[2*ph+1];
    return b;
  endfunction

  logic [7:0]  single_seq [5];
  logic [7:0]  starve_seq [5];
  logic [7:0]  x_seq      [5];
  logic [29:0] tbl        [20];
  int          exp_cnt;
  int          idx;
  logic        acc;

  initial begin
    single_seq = '{8'hCD, 8'hCD, 8'h4D, 8'h45, 8'h45};
    starve_seq = '{8'h88, 8'h8F, 8'h0F, 8'h07, 8'h77};
    x_seq      = '{8'h99, 8'h99, 8'h19, 8'h11, 8'h11};
    for (int i = 0; i < 20; i++)
      tbl[i] = {10'(i * 91 + 300), 10'(i * 53 + 17),
                10'(i * 37 + 5)};

    rst_n = 1'b0;
    en = 1'b0;
    s.sym_valid = 1'b0;
    s.sym_data = '0;
    repeat (2) tick();
    chk("rst_ddr", ddr_din, 8'h00);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_cnt", underrun_cnt, 0);
    chk("rst_ready", s.sym_ready, 1);
    rst_n = 1'b1;
    tick();

    // preload single symbol in IDLE
    s.sym_valid = 1'b1;
    s.sym_data = {10'h3FF, 10'h000, 10'h155};
    #1;
    chk("pre_ready", s.sym_ready, 1);
    tick();
    s.sym_valid = 1'b0;
    chk("pre_full_ready", s.sym_ready, 0);
    chk("pre_busy", busy, 0);
    chk("pre_ddr", ddr_din, 8'h00);
    en = 1'b1;
    #1;
    chk("start_ready", s.sym_ready, 1);
    for (int ph = 0; ph < 5; ph++) begin
      tick();
      chk("single_ddr", ddr_din, single_seq[ph]);
      chk("single_strobe", sym_strobe, ph == 0);
      chk("single_busy", busy, 1);
      chk("single_underrun", underrun, 0);
    end

    // starvation
    exp_cnt = 0;
    for (int n = 0; n < 4; n++) begin
      for (int ph = 0; ph < 5; ph++) begin
        tick();
        chk("starve_ddr", ddr_din, starve_seq[ph]);
        chk("starve_underrun", underrun, ph == 0);
        if (ph == 0) exp_cnt++;
        chk("starve_cnt", underrun_cnt, exp_cnt);
        if (n == 3 && ph == 0) break;
      end
    end

    // stop mid-symbol with a pending hold entry
    s.sym_valid = 1'b1;
    s.sym_data = {10'h000, 10'h000, 10'h3FF};
    tick();
    s.sym_valid = 1'b0;
    chk("stop_p1_ddr", ddr_din, 8'h8F);
    en = 1'b0;
    for (int ph = 2; ph < 5; ph++) begin
      tick();
      chk("stop_tail_ddr", ddr_din, starve_seq[ph]);
      chk("stop_tail_busy", busy, 1);
    end
    tick();
    chk("stop_ddr", ddr_din, 8'h00);
    chk("stop_busy", busy, 0);
    chk("stop_strobe", sym_strobe, 0);
    chk("stop_underrun", underrun, 0);
    chk("stop_hold_ready", s.sym_ready, 0);
    chk("stop_cnt", underrun_cnt, exp_cnt);
    tick();
    chk("idle_ddr", ddr_din, 8'h00);
    en = 1'b1;
    for (int ph = 0; ph < 5; ph++) begin
      tick();
      chk("resume_ddr", ddr_din, x_seq[ph]);
      chk("resume_strobe", sym_strobe, ph == 0);
      chk("resume_underrun", underrun, 0);
    end
    tick();
    exp_cnt++;
    chk("resume_starve_ddr", ddr_din, 8'h88);
    chk("resume_starve_underrun", underrun, 1);
    chk("resume_starve_cnt", underrun_cnt, exp_cnt);

    // asynchronous reset in the middle of RUN
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_ddr", ddr_din, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_strobe", sym_strobe, 0);
    chk("arst_cnt", underrun_cnt, 0);
    chk("arst_ready", s.sym_ready, 1);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_idle_ddr", ddr_din, 8'h00);

    // back-to-back streaming
    idx = 0;
    s.sym_valid = 1'b1;
    s.sym_data = tbl[0];
    tick();
    idx = 1;
    s.sym_data = tbl[1];
    chk("stream_pre_ready", s.sym_ready, 0);
    en = 1'b1;
    #1;
    chk("stream_start_ready", s.sym_ready, 1);
    tick();
    idx = 2;
    s.sym_data = tbl[2];
    for (int k = 0; k < 20; k++) begin
      for (int ph = 0; ph < 5; ph++) begin
        chk("stream_ddr", ddr_din, exp_byte(tbl[k], ph));
        chk("stream_strobe", sym_strobe, ph == 0);
        chk("stream_underrun", underrun, 0);
        chk("stream_busy", busy, 1);
        chk("stream_ready", s.sym_ready, (ph == 4) || (k == 19));
        if (k == 19 && ph == 0) en = 1'b0;
        acc = (ph == 4) && (idx < 20);
        tick();
        if (acc) begin
          idx++;
          if (idx < 20) s.sym_data = tbl[idx];
          else s.sym_valid = 1'b0;
        end
      end
    end
    chk("stream_end_ddr", ddr_din, 8'h00);
    chk("stream_end_busy", busy, 0);
    chk("stream_end_underrun", underrun, 0);
    chk("stream_end_cnt", underrun_cnt, 0);

    // start with empty buffer, then starve into saturation
    en = 1'b1;
    tick();
    chk("empty_start_ddr", ddr_din, 8'h88);
    chk("empty_start_strobe", sym_strobe, 1);
    chk("empty_start_underrun", underrun, 0);
    chk("empty_start_cnt", underrun_cnt, 0);
    for (int n = 1; n <= 20; n++) begin
      for (int ph = 1; ph < 5; ph++) begin
        tick();
        chk("sat_mid_underrun", underrun, 0);
      end
      tick();
      chk("sat_underrun", underrun, 1);
      chk("sat_cnt", underrun_cnt, (n < 15) ? n : 15);
      chk("sat_ddr", ddr_din, 8'h88);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
